llr_load_seq: RTL and testbench

Front-end sequencer for the LLR buffer memory: loads one frame of 64-bit, 8-LLR words into the buffer, then streams the whole frame back out as 4 LLRs per cycle. It generates the buffer's write enable, `i_code`, 128-entry rotate and four read positions, and presents the buffer's registered read data to the downstream decoding stage with valid/last flags. Frame length follows the code select: 64, 256 or 1024 LLRs.

---
 rtl/llr_load_seq.sv | 165 ++++++++++++++++
 tb/tb_llr_load_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/llr_load_seq.sv
// llr_load_seq: front-end sequencer for the LLR buffer memory.
// Loads one frame of 8-LLR words into the buffer, then streams the frame back
// out 4 LLRs per beat, one 128-entry window at a time. Between windows the
// buffer is rotated by 128 so the next window lands at positions 0..127.
module llr_load_seq (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [1:0]  i_code,
    input  logic        i_in_valid,
    input  logic [63:0] i_in_data,
    output logic        o_in_ready,
    output logic [1:0]  o_code,
    output logic        o_wen,
    output logic [63:0] o_wdata,
    output logic        o_rot128,
    output logic [6:0]  o_pos0,
    output logic [6:0]  o_pos1,
    output logic [6:0]  o_pos2,
    output logic [6:0]  o_pos3,
    input  logic [6:0]  i_llr0,
    input  logic [6:0]  i_llr1,
    input  logic [6:0]  i_llr2,
    input  logic [6:0]  i_llr3,
    output logic        o_out_valid,
    output logic [6:0]  o_llr0,
    output logic [6:0]  o_llr1,
    output logic [6:0]  o_llr2,
    output logic [6:0]  o_llr3,
    output logic        o_out_last,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        READ = 3'd2,
        ROT  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t     state;
    logic [6:0] word_cnt;
    logic [4:0] beat;
    logic [2:0] win;

    logic [6:0] last_word;
    logic [4:0] last_beat;
    logic [2:0] last_win;
    logic       end_beat;
    logic       end_frame;
    logic       reading;

    // Frame geometry limits derived from the latched code.
    always_comb begin
        last_word = 7'd127;
        last_beat = 5'd31;
        last_win  = 3'd7;
        case (o_code)
            2'd0: begin
                last_word = 7'd7;
                last_beat = 5'd15;
                last_win  = 3'd0;
            end
            2'd1: begin
                last_word = 7'd31;
                last_beat = 5'd31;
                last_win  = 3'd1;
            end
            default: begin
                last_word = 7'd127;
                last_beat = 5'd31;
                last_win  = 3'd7;
            end
        endcase
    end

    assign end_beat  = (beat == last_beat);
    assign end_frame = end_beat && (win == last_win);
    assign reading   = (state == READ);

    // Sequencer: state, counters, code latch and the one-cycle-late flags.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            word_cnt    <= 7'd0;
            beat        <= 5'd0;
            win         <= 3'd0;
            o_code      <= 2'd0;
            o_out_valid <= 1'b0;
            o_out_last  <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            // Read data returns one cycle after the positions, so the
            // valid/last flags trail the READ state by one cycle.
            o_out_valid <= reading;
            o_out_last  <= reading && end_frame;
            o_done      <= (state == DONE);
            o_err       <= (state == IDLE) && i_start && (i_code == 2'd3);
            case (state)
                IDLE: begin
                    if (i_start && (i_code != 2'd3)) begin
                        state    <= LOAD;
                        o_code   <= i_code;
                        word_cnt <= 7'd0;
                    end
                end
                LOAD: begin
                    if (i_in_valid) begin
                        word_cnt <= word_cnt + 7'd1;
                        if (word_cnt == last_word) begin
                            state <= READ;
                            beat  <= 5'd0;
                            win   <= 3'd0;
                        end
                    end
                end
                READ: begin
                    if (end_beat) begin
                        beat  <= 5'd0;
                        state <= (o_code == 2'd0) ? DONE : ROT;
                    end else begin
                        beat <= beat + 5'd1;
                    end
                end
                ROT: begin
                    // The last rotation brings the buffer back to load order.
                    if (win == last_win) begin
                        state <= DONE;
                    end else begin
                        win   <= win + 3'd1;
                        beat  <= 5'd0;
                        state <= READ;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign o_in_ready = (state == LOAD);
    assign o_wen      = i_in_valid & o_in_ready;
    assign o_wdata    = i_in_data;
    assign o_rot128   = (state == ROT);
    assign o_busy     = (state != IDLE);

    assign o_pos0 = reading ? {beat, 2'd0} : 7'd0;
    assign o_pos1 = reading ? {beat, 2'd1} : 7'd0;
    assign o_pos2 = reading ? {beat, 2'd2} : 7'd0;
    assign o_pos3 = reading ? {beat, 2'd3} : 7'd0;

    assign o_llr0 = i_llr0;
    assign o_llr1 = i_llr1;
    assign o_llr2 = i_llr2;
    assign o_llr3 = i_llr3;

endmodule

// File: tb/tb_llr_load_seq.sv
// Bench for llr_load_seq: random frame data, an LLR buffer model driven by the
// sequencer's control outputs, and a reference of where each beat's LLRs sit
// in the loaded frame.
module tb_llr_load_seq;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_start;
    logic [1:0]  i_code;
    logic        i_in_valid;
    logic [63:0] i_in_data;
    logic        o_in_ready;
    logic [1:0]  o_code;
    logic        o_wen;
    logic [63:0] o_wdata;
    logic        o_rot128;
    logic [6:0]  o_pos0, o_pos1, o_pos2, o_pos3;
    logic [6:0]  i_llr0, i_llr1, i_llr2, i_llr3;
    logic        o_out_valid;
    logic [6:0]  o_llr0, o_llr1, o_llr2, o_llr3;
    logic        o_out_last;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    llr_load_seq dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_code(i_code),
        .i_in_valid(i_in_valid), .i_in_data(i_in_data), .o_in_ready(o_in_ready),
        .o_code(o_code), .o_wen(o_wen), .o_wdata(o_wdata), .o_rot128(o_rot128),
        .o_pos0(o_pos0), .o_pos1(o_pos1), .o_pos2(o_pos2), .o_pos3(o_pos3),
        .i_llr0(i_llr0), .i_llr1(i_llr1), .i_llr2(i_llr2), .i_llr3(i_llr3),
        .o_out_valid(o_out_valid),
        .o_llr0(o_llr0), .o_llr1(o_llr1), .o_llr2(o_llr2), .o_llr3(o_llr3),
        .o_out_last(o_out_last), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- buffer model ----------------
    // Physical storage in load order plus a rotation offset; a read at
    // position p sees entry (p + 128*rot) mod frame_length.
    logic [6:0] mem [0:1023];
    int wptr = 0;
    int rot = 0;

    function automatic int view(input logic [6:0] p);
        int n;
        n = 64 << (2 * int'(o_code));
        return ((int'(p) + 128 * rot) % n) & 1023;
    endfunction

    always @(posedge i_clk) begin
        if (o_wen) begin
            for (int k = 0; k < 8; k++) mem[(wptr * 8 + k) & 1023] <= o_wdata[8*k +: 7];
            wptr <= wptr + 1;
        end else if (!o_busy) begin
            wptr <= 0;
        end
        if (o_rot128) rot <= rot + 1;
        else if (!o_busy) rot <= 0;
        i_llr0 <= mem[view(o_pos0)];
        i_llr1 <= mem[view(o_pos1)];
        i_llr2 <= mem[view(o_pos2)];
        i_llr3 <= mem[view(o_pos3)];
    end

    // ---------------- reference and monitor ----------------
    logic [6:0]  ref_llr [0:1023];
    logic [63:0] words [0:127];
    int cur_code = 0;
    int nbeat, nwen, nrot, first_v, done_c, last_c;
    int mw, mb, me, mtotal, mbpw;

    always @(negedge i_clk) begin
        if (i_rst_n) begin
            mbpw   = (cur_code == 0) ? 16 : 32;
            mtotal = 16 << (2 * cur_code);
            if (o_wen) nwen++;
            if (o_rot128) begin
                nrot++;
                chk("wen_rot_exclusive", o_wen, 0);
            end
            if (o_out_valid) begin
                if (first_v < 0) first_v = cyc;
                if (nbeat < mtotal) begin
                    mw = nbeat / mbpw;
                    mb = nbeat % mbpw;
                    me = 128 * mw + 4 * mb;
                    chk("llr0", o_llr0, ref_llr[me]);
                    chk("llr1", o_llr1, ref_llr[me + 1]);
                    chk("llr2", o_llr2, ref_llr[me + 2]);
                    chk("llr3", o_llr3, ref_llr[me + 3]);
                end
                chk("out_last", o_out_last, (nbeat == mtotal - 1));
                if (o_out_last) last_c = cyc;
                nbeat++;
            end
            if (o_done) done_c = cyc;
        end
    end

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_ready"}, o_in_ready, 0);
        chk({tag, "_wen"}, o_wen, 0);
        chk({tag, "_rot"}, o_rot128, 0);
        chk({tag, "_pos"}, {o_pos0, o_pos1, o_pos2, o_pos3}, 0);
        chk({tag, "_valid"}, o_out_valid, 0);
        chk({tag, "_last"}, o_out_last, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_err"}, o_err, 0);
    endtask

    // mode: 0 back-to-back words, 1 valid toggling 1/0, 2 random stalls.
    // poke: raise i_start during READ. abort_beat > 0: reset after that many beats.
    task automatic run_frame(input int code, input int mode, input bit poke, input int abort_beat);
        int nw, exp_beats, exp_rot, exp_lat, exp_gap, seed, idx, guard, n;
        logic [7:0] byt;
        bit v;
        nw        = 8 << (2 * code);
        exp_beats = 16 << (2 * code);
        exp_rot   = (code == 0) ? 0 : ((code == 1) ? 2 : 8);
        exp_lat   = (code == 0) ? 16 : ((code == 1) ? 66 : 264);
        exp_gap   = (code == 0) ? 1 : 2;
        n         = 64 << (2 * code);
        seed      = (code == 0) ? 0 : int'($urandom_range(0, 127));
        for (int j = 0; j < nw; j++) begin
            for (int k = 0; k < 8; k++) begin
                byt = 8'((8 * j + k + seed) & 127);
                if (code != 0) byt[7] = 1'($urandom_range(0, 1));
                words[j][8*k +: 8] = byt;
                ref_llr[8 * j + k] = byt[6:0];
            end
        end
        cur_code = code;
        nbeat = 0; nwen = 0; nrot = 0; first_v = -1; done_c = -1; last_c = -1;

        @(negedge i_clk);
        i_start = 1'b1;
        i_code  = 2'(code);
        @(negedge i_clk);
        i_start = 1'b0;
        chk("busy_after_start", o_busy, 1);
        chk("ready_in_load", o_in_ready, 1);
        chk("code_latched", o_code, code);

        idx = 0;
        guard = 0;
        while (idx < nw && guard < 2000) begin
            if (mode == 0) v = 1'b1;
            else if (mode == 1) v = ((guard % 2) == 0);
            else v = 1'($urandom_range(0, 1));
            i_in_valid = v;
            i_in_data  = words[idx];
            @(negedge i_clk);
            if (v) idx++;
            guard++;
        end
        i_in_valid = 1'b0;
        i_in_data  = {$urandom, $urandom};
        chk("load_complete", idx, nw);
        chk("ready_after_load", o_in_ready, 0);

        if (abort_beat > 0) begin
            guard = 0;
            while (nbeat < abort_beat && guard < 3000) begin
                @(negedge i_clk);
                guard++;
            end
            chk("abort_point_reached", (nbeat >= abort_beat), 1);
            i_rst_n = 1'b0;
            @(negedge i_clk);
            chk_idle_outputs("midreset");
            chk("midreset_code", o_code, 0);
            i_rst_n = 1'b1;
            @(negedge i_clk);
            chk_idle_outputs("after_reset");
            return;
        end

        if (poke) begin
            guard = 0;
            while (nbeat < 4 && guard < 3000) begin
                @(negedge i_clk);
                guard++;
            end
            i_start = 1'b1;
            i_code  = 2'd2;
            @(negedge i_clk);
            @(negedge i_clk);
            i_start = 1'b0;
            i_code  = 2'(code);
            chk("poke_code_kept", o_code, code);
            chk("poke_still_busy", o_busy, 1);
        end

        guard = 0;
        while (done_c < 0 && guard < 3000) begin
            @(negedge i_clk);
            guard++;
        end
        chk("done_seen", (done_c >= 0), 1);
        chk("wen_count", nwen, nw);
        chk("beat_count", nbeat, exp_beats);
        chk("rot_count", nrot, exp_rot);
        chk("done_latency", done_c - first_v, exp_lat);
        chk("done_after_last", done_c - last_c, exp_gap);
        chk("buffer_order_restored", (rot * 128) % n, 0);
        chk("busy_at_done", o_busy, 0);
        @(negedge i_clk);
        chk("done_one_cycle", o_done, 0);
    endtask

    initial begin
        i_rst_n    = 1'b0;
        i_start    = 1'b0;
        i_code     = 2'd0;
        i_in_valid = 1'b0;
        i_in_data  = 64'd0;
        repeat (3) @(negedge i_clk);
        chk_idle_outputs("reset");
        chk("reset_code", o_code, 0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        run_frame(0, 0, 1'b0, 0);
        run_frame(1, 1, 1'b0, 0);
        run_frame(2, 2, 1'b0, 0);

        // Illegal code: error pulse, no frame.
        @(negedge i_clk);
        i_start = 1'b1;
        i_code  = 2'd3;
        @(negedge i_clk);
        i_start = 1'b0;
        i_code  = 2'd0;
        chk("err_pulse", o_err, 1);
        chk("err_not_busy", o_busy, 0);
        @(negedge i_clk);
        chk("err_one_cycle", o_err, 0);
        chk("err_still_idle", o_busy, 0);
        run_frame(0, 0, 1'b0, 0);

        run_frame(0, 0, 1'b1, 0);
        run_frame(2, 0, 1'b0, 40);
        run_frame(1, 2, 1'b0, 0);

        repeat (2) @(negedge i_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
